// File: rtl/elelock_ctrl.sv
// Keypad door lock: 4-digit BCD code entry, open/relock, and a timed lockout after repeated wrong codes.
// Latency: outputs update at the accepting ck edge. Backpressure: none; keys are level-sampled and the user re-presses.
// Optional password change in OPEN is enabled by defining ELELOCK_PWCHANGE_EN.
module elelock_ctrl #(
    parameter logic [15:0] PASSWORD       = 16'h5937,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic       ck,
    input  logic       reset_n,
    input  logic [9:0] tenkey,
    input  logic       close,
    output logic       lock,
    output logic       alarm,
    output logic [2:0] digit_cnt,
    output logic [1:0] fail_cnt,
    output logic       pw_set
);

    localparam logic [1:0] MAX_FAIL_L = 2'(MAX_FAIL);
    localparam logic [7:0] LO_LOAD    = 8'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {LOCKED, OPEN, LOCKOUT} state_t;

    state_t      state, state_nx;
    logic [9:0]  key_prev;
    logic [15:0] entry, entry_nx, entry_full;
    logic [15:0] pw, pw_nx;
    logic [2:0]  dcnt_nx;
    logic [1:0]  fcnt_nx;
    logic [7:0]  lo_cnt, lo_cnt_nx;
    logic        pw_set_nx;
    logic        key_ok;
    logic [3:0]  key_dig;

    // A digit counts only on a clean press: exactly one key, after an all-released cycle.
    always_comb begin
        key_dig = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (tenkey[i]) key_dig = 4'(i);
        end
        key_ok     = (key_prev == '0) && (tenkey != '0) && ((tenkey & (tenkey - 10'd1)) == '0);
        entry_full = {entry[11:0], key_dig};
    end

    always_comb begin
        state_nx  = state;
        entry_nx  = entry;
        dcnt_nx   = digit_cnt;
        fcnt_nx   = fail_cnt;
        lo_cnt_nx = lo_cnt;
        pw_nx     = pw;
        pw_set_nx = 1'b0;
        case (state)
            LOCKED: begin
                if (close) begin
                    entry_nx = '0;
                    dcnt_nx  = 3'd0;
                end else if (key_ok) begin
                    if (digit_cnt == 3'd3) begin
                        entry_nx = '0;
                        dcnt_nx  = 3'd0;
                        if (entry_full == pw) begin
                            state_nx = OPEN;
                            fcnt_nx  = 2'd0;
                        end else begin
                            fcnt_nx = fail_cnt + 2'd1;
                            if (fcnt_nx == MAX_FAIL_L) begin
                                state_nx  = LOCKOUT;
                                lo_cnt_nx = LO_LOAD;
                            end
                        end
                    end else begin
                        entry_nx = entry_full;
                        dcnt_nx  = digit_cnt + 3'd1;
                    end
                end
            end
            OPEN: begin
                if (close) begin
                    state_nx = LOCKED;
                    entry_nx = '0;
                    dcnt_nx  = 3'd0;
                end
`ifdef ELELOCK_PWCHANGE_EN
                else if (key_ok) begin
                    if (digit_cnt == 3'd3) begin
                        pw_nx     = entry_full;
                        pw_set_nx = 1'b1;
                        entry_nx  = '0;
                        dcnt_nx   = 3'd0;
                    end else begin
                        entry_nx = entry_full;
                        dcnt_nx  = digit_cnt + 3'd1;
                    end
                end
`endif
            end
            LOCKOUT: begin
                if (lo_cnt == 8'd0) begin
                    state_nx = LOCKED;
                    fcnt_nx  = 2'd0;
                    dcnt_nx  = 3'd0;
                    entry_nx = '0;
                end else begin
                    lo_cnt_nx = lo_cnt - 8'd1;
                end
            end
            default: state_nx = LOCKED;
        endcase
    end

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOCKED;
            key_prev  <= '0;
            entry     <= '0;
            digit_cnt <= 3'd0;
            fail_cnt  <= 2'd0;
            lo_cnt    <= 8'd0;
            pw        <= PASSWORD;
            pw_set    <= 1'b0;
        end else begin
            state     <= state_nx;
            key_prev  <= tenkey;
            entry     <= entry_nx;
            digit_cnt <= dcnt_nx;
            fail_cnt  <= fcnt_nx;
            lo_cnt    <= lo_cnt_nx;
            pw        <= pw_nx;
            pw_set    <= pw_set_nx;
        end
    end

    assign lock  = (state != OPEN);
    assign alarm = (state == LOCKOUT);

endmodule

// File: doc/elelock_ctrl.md
ELELOCK_CTRL -- requirements
Module: elelock_ctrl

Interface
REQ-001 Parameter PASSWORD, default 16'h5937: four BCD digits, first-entered digit in [15:12].
REQ-002 Parameter MAX_FAIL, default 3: consecutive wrong codes that trigger lockout, legal range 1..3.
REQ-003 Parameter LOCKOUT_CYCLES, default 16: lockout duration in ck cycles, legal range 2..255.
REQ-004 ck  input  1  system clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 tenkey  input  10  keypad level inputs; bit i high means digit i is held.
REQ-007 close  input  1  door-closed/relock request, level, sampled each edge.
REQ-008 lock  output  1  1 = bolt engaged.
REQ-009 alarm  output  1  1 while in LOCKOUT.
REQ-010 digit_cnt  output  3  digits in the current entry, 0..3.
REQ-011 fail_cnt  output  2  consecutive wrong codes.
REQ-012 pw_set  output  1  one-cycle pulse when the password register is rewritten (config-dependent).

Function
REQ-013 Key accept: a registered copy key_prev holds last cycle's tenkey; a digit is accepted at an edge when tenkey is exactly one-hot and key_prev == 0.
REQ-014 Multi-key, held keys and any press while key_prev != 0 are ignored; a repress requires at least one all-zero cycle.
REQ-015 States: LOCKED, OPEN, LOCKOUT; encoding is free.
REQ-016 LOCKED: an accepted digit shifts into a 16-bit entry buffer (buf <= {buf[11:0], d}) and digit_cnt increments.
REQ-017 LOCKED, 4th digit: at the accepting edge, {buf[11:0], d} is compared with the password register, and digit_cnt and buf clear.
REQ-018 Match: next state OPEN, lock falls at that same edge, and fail_cnt clears.
REQ-019 Mismatch: fail_cnt increments; if the new value equals MAX_FAIL, next state is LOCKOUT and alarm rises at that edge.
REQ-020 LOCKED with close=1: buf and digit_cnt clear; a digit accepted in the same cycle is discarded.
REQ-021 OPEN with close=1: next state LOCKED, lock rises at that edge, and buf and digit_cnt clear.
REQ-022 LOCKOUT: a down-counter is loaded with LOCKOUT_CYCLES-1 on entry and decrements each cycle; keys and close are ignored.
REQ-023 LOCKOUT exit: when the counter is 0, next state is LOCKED, and fail_cnt, alarm and digit_cnt clear; total time in LOCKOUT is exactly LOCKOUT_CYCLES cycles.
REQ-024 lock is 0 only in OPEN; alarm is 1 only in LOCKOUT; pw_set is 0 except as in REQ-030.

Reset
REQ-025 reset_n=0 asynchronously forces: state LOCKED, lock=1, alarm=0, digit_cnt=0, fail_cnt=0, pw_set=0, buf=0, key_prev=0, lockout counter=0, password register=PASSWORD.
REQ-026 Reset asserted mid-entry, in OPEN or in LOCKOUT abandons the operation with no residual state.
REQ-027 The first rising edge after reset_n rises performs normal operation.

Configuration
REQ-028 The macro ELELOCK_PWCHANGE_EN controls password change; undefined gives a read-only password fixed at PASSWORD, with keys in OPEN ignored and pw_set tied 0.
REQ-029 Defined, OPEN: accepted digits collect into buf/digit_cnt as in REQ-016.
REQ-030 Defined, 4th digit in OPEN: the password register loads {buf[11:0], d}, pw_set pulses one cycle, buf/digit_cnt clear, and the state stays OPEN.
REQ-031 Defined, OPEN with close=1: a partial new code is discarded; close wins over a simultaneous 4th digit.

Verification
REQ-032 Reset, then keys 5,9,3,7 (each 4 cycles high, 4 low) -> lock=0 at 4th press edge, fail_cnt=0; then close pulse -> lock=1.
REQ-033 Keys 1,2,3,4 three times (MAX_FAIL=3) -> fail_cnt 1,2, then alarm=1; then alarm=1 for exactly 16 cycles with key presses ignored; then LOCKED with fail_cnt=0.
REQ-034 tenkey=10'b0000100001 then a held key then 5 -> only digit 5 accepted (digit_cnt=1); a close pulse then -> digit_cnt=0.
REQ-035 reset_n pulsed low between edges during OPEN -> lock=1 immediately, before the next edge.
REQ-036 With ELELOCK_PWCHANGE_EN: open, enter 2,4,6,8 -> pw_set pulse; close; then 5,9,3,7 -> fail_cnt=1; then 2,4,6,8 -> lock=0. Without the macro, the same sequence leaves PASSWORD unchanged and pw_set=0 throughout.
